// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_core
// Description : Multi-cycle CPU core. One FSM steps through FETCH, DECODE,
//               EXEC, MEM and WB. All steps share one register bank and one
//               ALU. A single req/ack port to unified memory carries both
//               instruction fetches and data accesses, so the core tolerates
//               memory with variable latency.
// Ports       : clk        rising-edge clock
//               reset      synchronous, active-high
//               mem_req    memory request, held until mem_ack
//               mem_we     1 = write (STR), 0 = read (fetch / LDR)
//               mem_addr   byte address [ADDR_W]
//               mem_wdata  store data [DATA_W]
//               mem_rdata  read data, valid in the ack cycle [DATA_W]
//               mem_ack    completes the transfer while mem_req is high
//               pc_out     current PC [ADDR_W]
//               zero       result of the last ALU-class EXEC was zero
//               halted     core is in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_core #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                REG_N    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              zero,
    output logic              halted
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_ORR  = 4'd3;
    localparam logic [3:0] c_OP_ADDI = 4'd4;
    localparam logic [3:0] c_OP_LDR  = 4'd5;
    localparam logic [3:0] c_OP_STR  = 4'd6;
    localparam logic [3:0] c_OP_CBZ  = 4'd7;
    localparam logic [3:0] c_OP_B    = 4'd8;
    localparam logic [3:0] c_OP_HALT = 4'd15;

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [15:0]       r_imm;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;

    logic [3:0]        w_op;
    logic [3:0]        w_rd;
    logic [3:0]        w_rn;
    logic [3:0]        w_rm;
    logic [3:0]        w_bIdx;
    logic [DATA_W-1:0] w_simm;
    logic [ADDR_W-1:0] w_brOff;
    logic [DATA_W-1:0] w_aluOut;
    logic [31:0]       w_fetchWord;
    logic              w_wbEn;
    logic [DATA_W-1:0] w_regFile [16];

    assign w_op   = r_ir[31:28];
    assign w_rd   = r_ir[27:24];
    assign w_rn   = r_ir[23:20];
    assign w_rm   = r_ir[19:16];
    // STR reads its data register through the B operand path.
    assign w_bIdx = (w_op == c_OP_STR) ? w_rd : w_rm;

    assign w_simm      = DATA_W'($signed(r_imm));
    // The 18-bit {imm,00} is the byte offset simm<<2. Sign-extend it (or
    // truncate it) to the PC width.
    assign w_brOff     = ADDR_W'($signed({r_imm, 2'b00}));
    assign w_fetchWord = 32'(mem_rdata);
    assign w_wbEn      = (r_state == c_ST_WB);

    // ------------------------------------------------------------------------
    // Register bank. R0 and every index at or above REG_N are hard zeros, so a
    // read needs no range check and writes to those indices have no effect.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_regs
            if (gi == 0 || gi >= REG_N) begin : g_zero
                assign w_regFile[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_val;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_val <= '0;
                    end else if (w_wbEn && (w_rd == 4'(gi))) begin
                        r_val <= r_result;
                    end
                end
                assign w_regFile[gi] = r_val;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // ALU. LDR and STR reuse the ADDI path to form the address.
    // ------------------------------------------------------------------------
    always_comb begin
        w_aluOut = '0;
        case (w_op)
            c_OP_ADD:                      w_aluOut = r_a + r_b;
            c_OP_SUB:                      w_aluOut = r_a - r_b;
            c_OP_AND:                      w_aluOut = r_a & r_b;
            c_OP_ORR:                      w_aluOut = r_a | r_b;
            c_OP_ADDI, c_OP_LDR, c_OP_STR: w_aluOut = r_a + w_simm;
            default:                       w_aluOut = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= w_fetchWord;
                        r_state <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    r_a     <= w_regFile[w_rn];
                    r_b     <= w_regFile[w_bIdx];
                    r_imm   <= r_ir[15:0];
                    r_state <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    r_result <= w_aluOut;
                    if (w_op <= c_OP_STR) begin
                        r_zero <= (w_aluOut == '0);
                    end
                    case (w_op)
                        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_ORR, c_OP_ADDI: begin
                            r_state <= c_ST_WB;
                        end
                        c_OP_LDR, c_OP_STR: begin
                            r_state <= c_ST_MEM;
                        end
                        c_OP_CBZ: begin
                            r_pc    <= (r_a == '0) ? (r_pc + w_brOff) : (r_pc + c_PC_STEP);
                            r_state <= c_ST_FETCH;
                        end
                        c_OP_B: begin
                            r_pc    <= r_pc + w_brOff;
                            r_state <= c_ST_FETCH;
                        end
                        c_OP_HALT: begin
                            r_state <= c_ST_HALT;
                        end
                        default: begin
                            r_pc    <= r_pc + c_PC_STEP;
                            r_state <= c_ST_FETCH;
                        end
                    endcase
                end
                c_ST_MEM: begin
                    if (mem_ack) begin
                        if (w_op == c_OP_STR) begin
                            r_pc    <= r_pc + c_PC_STEP;
                            r_state <= c_ST_FETCH;
                        end else begin
                            // Load data goes into r_result, so WB needs only one write source.
                            r_result <= mem_rdata;
                            r_state  <= c_ST_WB;
                        end
                    end
                end
                c_ST_WB: begin
                    r_pc    <= r_pc + c_PC_STEP;
                    r_state <= c_ST_FETCH;
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Memory port and status. Every output comes from registers only, so all
    // of them stay stable while an access waits for ack.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req   = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM);
        mem_we    = (r_state == c_ST_MEM) && (w_op == c_OP_STR);
        mem_addr  = (r_state == c_ST_MEM) ? ADDR_W'(r_result) : r_pc;
        mem_wdata = r_b;
        pc_out    = r_pc;
        zero      = r_zero;
        halted    = (r_state == c_ST_HALT);
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_core
// Description : Directed self-checking bench for multicycle_core. It provides
//               a unified memory model. Reads from 0x000-0x0FF always ack in
//               the request cycle. Reads above 0x0FF ack after dataDelay wait
//               cycles. Every completed store is logged.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] pc_out;
    logic        zero;
    logic        halted;

    multicycle_core #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .REG_N    (16),
        .RESET_PC (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_out    (pc_out),
        .zero      (zero),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] progMem [256];
    int          dataDelay = 0;
    int          waitCnt = 0;
    logic [31:0] storeAddr [128];
    logic [31:0] storeData [128];
    int          storeCnt = 0;

    assign mem_ack   = mem_req && ((mem_addr[9:8] == 2'b00) || (waitCnt >= dataDelay));
    assign mem_rdata = progMem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
        else                     waitCnt <= 0;
        if (mem_req && mem_ack && mem_we && !reset && storeCnt < 128) begin
            storeAddr[storeCnt] <= mem_addr;
            storeData[storeCnt] <= mem_wdata;
            storeCnt            <= storeCnt + 1;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    int pcCycles [256];
    int dataReqCycles;
    int unstable = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rn, input logic [3:0] rm,
                                        input logic [15:0] imm);
        return {op, rd, rn, rm, imm};
    endfunction

    function automatic logic [31:0] storedAt(input logic [31:0] a, input int fromIdx);
        logic [31:0] v;
        v = 32'hBAD0_BAD0;
        for (int i = fromIdx; i < storeCnt; i++) begin
            if (storeAddr[i] == a) v = storeData[i];
        end
        return v;
    endfunction

    task automatic fillHalt();
        for (int i = 0; i < 256; i++) progMem[i] = 32'hF000_0000;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at the negedge just after reset is released. Samples one cycle per negedge.
    task automatic runToHalt(input int budget);
        int          n;
        logic        pendPrev;
        logic [31:0] addrPrev;
        logic [31:0] wdataPrev;
        logic        wePrev;
        n        = 0;
        pendPrev = 1'b0;
        addrPrev = '0;
        wdataPrev = '0;
        wePrev   = 1'b0;
        dataReqCycles = 0;
        for (int i = 0; i < 256; i++) pcCycles[i] = 0;
        while (!halted && n < budget) begin
            pcCycles[pc_out[9:2]]++;
            if (mem_req && !mem_we && mem_addr[9:8] != 2'b00) dataReqCycles++;
            if (pendPrev && (!mem_req || mem_addr !== addrPrev || mem_we !== wePrev ||
                             (mem_we && mem_wdata !== wdataPrev))) unstable++;
            pendPrev  = mem_req && !mem_ack;
            addrPrev  = mem_addr;
            wePrev    = mem_we;
            wdataPrev = mem_wdata;
            @(negedge clk);
            n++;
        end
        checkEq("haltReached", {31'b0, halted}, 32'h1);
    endtask

    initial begin
        int base;
        int bad;
        int n;

        // ---- 1 + 2: reset state, ALU ops, store ----
        fillHalt();
        progMem[0] = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'd5);      // ADDI R1,R0,5
        progMem[1] = enc(4'd4, 4'd2, 4'd0, 4'd0, 16'hFFFD);   // ADDI R2,R0,-3
        progMem[2] = enc(4'd0, 4'd3, 4'd1, 4'd2, 16'd0);      // ADD  R3,R1,R2
        progMem[3] = enc(4'd6, 4'd3, 4'd0, 4'd0, 16'h40);     // STR  R3,[R0,#0x40]
        progMem[4] = enc(4'd2, 4'd5, 4'd1, 4'd2, 16'd0);      // AND  R5,R1,R2
        progMem[5] = enc(4'd3, 4'd6, 4'd1, 4'd2, 16'd0);      // ORR  R6,R1,R2
        progMem[6] = enc(4'd6, 4'd5, 4'd0, 4'd0, 16'h44);     // STR  R5,[R0,#0x44]
        progMem[7] = enc(4'd6, 4'd6, 4'd0, 4'd0, 16'h48);     // STR  R6,[R0,#0x48]
        dataDelay = 0;
        doReset();
        checkEq("rstMemReq", {31'b0, mem_req}, 32'h1);
        checkEq("rstMemAddr", mem_addr, 32'h0);
        checkEq("rstPc", pc_out, 32'h0);
        checkEq("rstHalted", {31'b0, halted}, 32'h0);
        checkEq("rstZero", {31'b0, zero}, 32'h0);
        base = storeCnt;
        runToHalt(300);
        checkEq("t2AddStore", storedAt(32'h40, base), 32'h2);
        checkEq("t2AndStore", storedAt(32'h44, base), 32'h5);
        checkEq("t2OrrStore", storedAt(32'h48, base), 32'hFFFF_FFFD);
        checkEq("t2Zero", {31'b0, zero}, 32'h0);
        checkEq("t2AddCycles", pcCycles[2], 32'd4);
        checkEq("t2StrCycles", pcCycles[3], 32'd4);
        checkEq("t2HaltPc", pc_out, 32'h20);

        // ---- 3a: SUB to zero, CBZ taken ----
        fillHalt();
        progMem[0] = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'd9);      // ADDI R1,R0,9
        progMem[1] = enc(4'd1, 4'd4, 4'd1, 4'd1, 16'd0);      // SUB  R4,R1,R1
        progMem[2] = enc(4'd7, 4'd0, 4'd4, 4'd0, 16'd2);      // CBZ  R4,+2 -> 0x10
        progMem[3] = enc(4'd4, 4'd5, 4'd0, 4'd0, 16'd1);      // skipped
        doReset();
        runToHalt(200);
        checkEq("t3Zero", {31'b0, zero}, 32'h1);
        checkEq("t3CbzCycles", pcCycles[2], 32'd3);
        checkEq("t3Skipped", pcCycles[3], 32'd0);
        checkEq("t3HaltPc", pc_out, 32'h10);

        // ---- 3b: CBZ not taken, forward and backward B ----
        fillHalt();
        progMem[0] = enc(4'd4, 4'd4, 4'd0, 4'd0, 16'd7);      // ADDI R4,R0,7
        progMem[1] = enc(4'd7, 4'd0, 4'd4, 4'd0, 16'd2);      // CBZ  R4,+2 (not taken)
        progMem[2] = enc(4'd4, 4'd6, 4'd0, 4'd0, 16'h55);     // ADDI R6,R0,0x55
        progMem[3] = enc(4'd6, 4'd6, 4'd0, 4'd0, 16'h4C);     // STR  R6,[R0,#0x4C]
        progMem[4] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd3);      // B +3 -> 0x1C
        progMem[7] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'hFFFE);   // B -2 -> 0x14
        base = storeCnt;
        doReset();
        runToHalt(200);
        checkEq("t3NtStore", storedAt(32'h4C, base), 32'h55);
        checkEq("t3NtCycles", pcCycles[2], 32'd4);
        checkEq("t3BSkip", pcCycles[6], 32'd0);
        checkEq("t3BCycles", pcCycles[7], 32'd3);
        checkEq("t3BHaltPc", pc_out, 32'h14);
        checkEq("t3BZero", {31'b0, zero}, 32'h0);

        // ---- 4: LDR with three wait cycles ----
        fillHalt();
        progMem[0]    = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'h200); // ADDI R1,R0,0x200
        progMem[1]    = enc(4'd5, 4'd7, 4'd1, 4'd0, 16'd0);   // LDR  R7,[R1,#0]
        progMem[2]    = enc(4'd6, 4'd7, 4'd0, 4'd0, 16'h50);  // STR  R7,[R0,#0x50]
        progMem[8'h80] = 32'hCAFE_BABE;
        dataDelay = 3;
        base = storeCnt;
        doReset();
        runToHalt(200);
        checkEq("t4LdrCycles", pcCycles[1], 32'd8);
        checkEq("t4ReqCycles", dataReqCycles, 32'd4);
        checkEq("t4LdData", storedAt(32'h50, base), 32'hCAFE_BABE);
        checkEq("t4Stable", unstable, 32'd0);
        dataDelay = 0;

        // ---- 5: HALT is terminal until reset ----
        fillHalt();
        progMem[0] = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'd1);      // ADDI R1,R0,1
        doReset();
        runToHalt(100);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req || !halted || pc_out !== 32'h4) bad++;
        end
        checkEq("t5Frozen", bad, 32'd0);
        doReset();
        checkEq("t5RstPc", pc_out, 32'h0);
        checkEq("t5RstReq", {31'b0, mem_req}, 32'h1);
        checkEq("t5RstHalted", {31'b0, halted}, 32'h0);
        runToHalt(100);
        checkEq("t5RerunPc", pc_out, 32'h4);

        // ---- 6: reset lands on an acked LDR ----
        fillHalt();
        progMem[0]     = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'd7);    // ADDI R1,R0,7
        progMem[1]     = enc(4'd5, 4'd2, 4'd0, 4'd0, 16'h200);  // LDR  R2,[R0,#0x200]
        progMem[8'h80] = 32'h0000_1234;
        doReset();
        n = 0;
        while (!(mem_req && !mem_we && mem_addr == 32'h200) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkEq("t6InMem", mem_addr, 32'h200);
        checkEq("t6AckHigh", {31'b0, mem_ack}, 32'h1);
        reset = 1'b1;
        for (int i = 1; i < 16; i++) begin
            progMem[i-1] = enc(4'd6, 4'(i), 4'd0, 4'd0, 16'(32'h300 + 4 * i));
        end
        progMem[15] = 32'hF000_0000;
        @(negedge clk);
        reset = 1'b0;
        checkEq("t6RstPc", pc_out, 32'h0);
        checkEq("t6RstAddr", mem_addr, 32'h0);
        base = storeCnt;
        runToHalt(400);
        for (int i = 1; i < 16; i++) begin
            checkEq($sformatf("t6Reg%0d", i), storedAt(32'h300 + 4 * i, base), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
